// File: rtl/led_pulse_out.sv
// Turns 1-cycle event strobes into visible LED blinks (ON_TICKS lit, OFF_TICKS dark).
// Events arriving mid-blink are queued in a saturating counter and replayed back-to-back.
module led_pulse_out #(
  parameter int BIT_SIZE  = 20,
  parameter int ON_TICKS  = 4,
  parameter int OFF_TICKS = 2,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             i_sclr,
  input  logic             i_pulse,
  output logic             o_led,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_pending,
  output logic             o_ovf
);

  localparam int MAX_T   = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TIMER_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_TICKS - 1);
  localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(OFF_TICKS - 1);
  localparam logic [CNT_W-1:0]   PEND_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ON,
    ST_GAP
  } state_t;

  state_t               state;
  logic [BIT_SIZE-1:0]  prescaler;
  logic [TIMER_W-1:0]   timer;
  logic                 tick;
  logic                 pend_nz;
  logic                 start;

  assign tick    = &prescaler;
  assign pend_nz = |o_pending;

  // A blink starts from IDLE, or straight out of an expired GAP when work is queued.
  assign start = tick && pend_nz &&
                 ((state == ST_IDLE) || ((state == ST_GAP) && (timer == '0)));

  always_ff @(posedge clk) begin
    if (i_sclr) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_sclr) begin
      o_pending <= '0;
      o_ovf     <= 1'b0;
    end else begin
      case ({i_pulse, start})
        2'b10: begin
          if (o_pending != PEND_MAX) begin
            o_pending <= o_pending + 1'b1;
          end else begin
            o_ovf <= 1'b1;
          end
        end
        2'b01: o_pending <= o_pending - 1'b1;
        default: ;
      endcase
    end
  end

  // o_led/o_busy are updated alongside the state so they track it with no extra lag.
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      state  <= ST_IDLE;
      timer  <= '0;
      o_led  <= 1'b0;
      o_busy <= 1'b0;
    end else if (tick) begin
      case (state)
        ST_IDLE: begin
          if (pend_nz) begin
            state  <= ST_ON;
            timer  <= ON_LOAD;
            o_led  <= 1'b1;
            o_busy <= 1'b1;
          end
        end
        ST_ON: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else begin
            state <= ST_GAP;
            timer <= OFF_LOAD;
            o_led <= 1'b0;
          end
        end
        ST_GAP: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else if (pend_nz) begin
            state <= ST_ON;
            timer <= ON_LOAD;
            o_led <= 1'b1;
          end else begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          timer  <= '0;
          o_led  <= 1'b0;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
